irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped interrupt controller directly downstream of the timer peripheral.
- Collects the timer IRQ and other peripheral interrupt lines, latches them as pending, and applies a mask and a fixed priority.
- Presents a single interrupt request to the CPU, with an ack / end-of-interrupt (EOI) handshake.
- Sits on the same peripheral bus as the timer (en/wen/address/din/dout).

Parameters:
- NSRC, 8, number of interrupt sources, legal range 1..32. src[0] is wired to the timer IRQ.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  reset; asynchronous, active-low (0 = reset).
- en  input  1  peripheral select from bus decoder.
- wen  input  1  write strobe; a write occurs only when en & wen.
- address  input  32  byte address; only address[4:0] decoded.
- din  input  32  write data.
- dout  output  32  read data, combinational.
- src  input  NSRC  interrupt source lines, synchronous to clk.
- irq_ack  input  1  CPU acknowledges the request (1-cycle pulse on exception entry).
- irq_out  output  1  interrupt request to CPU.

Behaviour:
- Registers (offset address[4:0]):
  - 0x00 PENDING: read; write-1-to-clear.
  - 0x04 MASK: read/write, 1 = enabled.
  - 0x08 EDGE: read/write; 1 = rising-edge sensitive, 0 = level.
  - 0x0C CAUSE: read-only. Bit 31 = valid; bits 4:0 = id of the highest-priority masked pending source; all other bits 0.
  - 0x10 EOI: write-only; any write performs EOI; reads 0.
  - Other offsets: read 0, writes ignored.
- Only bits NSRC-1:0 are implemented in PENDING, MASK and EDGE; upper bits read 0.
- dout = 0 when en = 0. Reads have 0-cycle latency (combinational, like the timer).
- Reset (reset = 0, asynchronous) clears PENDING, MASK, EDGE, src_prev and cur_id, and sets state = IDLE, so irq_out = 0 and dout = 0.
- src_prev is src registered every cycle.
- Pending set term per bit i:
  - edge mode: src[i] & ~src_prev[i];
  - level mode: src[i].
- Pending clear term per bit i: a PENDING write with din[i] = 1, or an EOI in IN_SERVICE with i == cur_id.
- Set and clear in the same cycle: set wins, so pending[i] stays 1.
- In level mode, a cleared bit re-sets on the next edge while src[i] is still high.
- masked = PENDING & MASK.
- Priority: the lowest index wins.
- FSM (irq_out = 1 only in REQUEST, decoded from registered state):
  - IDLE: if masked != 0, go to REQUEST next edge.
  - REQUEST:
    - irq_ack = 1: latch cur_id = current priority id, go to IN_SERVICE.
    - else if masked == 0 (cleared by a mask or PENDING write): go to IDLE, request withdrawn.
    - irq_ack and masked == 0 in the same cycle: take the masked == 0 branch; the ack is ignored.
  - IN_SERVICE: irq_out = 0, no nesting. An EOI write clears pending[cur_id] (set-wins still applies) and goes to IDLE.
  - irq_ack in IDLE or IN_SERVICE: ignored. EOI outside IN_SERVICE: no effect.
- Latency: src rises before edge k → pending set at edge k → REQUEST at edge k+1 → irq_out high after k+1, i.e. 2 cycles.
- After EOI, if other masked pending bits remain: IDLE for one cycle, then REQUEST again.
- cur_id width is 5 bits, zero-extended in CAUSE.

Test Plan:
- Reset: hold reset = 0, then release → all register reads 0, irq_out = 0. Assert reset = 0 mid-cycle while irq_out = 1 → irq_out = 0 immediately, without waiting for a clock edge.
- Level timer source: MASK = 0x01, EDGE = 0x00. Raise src[0] before edge k → PENDING = 0x01 after k, irq_out = 1 after k+1, CAUSE = 0x80000000.
- Priority and EOI: MASK = 0xFF, EDGE = 0xFF, rising edges on src[3] and src[5] in the same cycle.
  - CAUSE = 0x80000003, irq_out = 1.
  - Pulse irq_ack → irq_out = 0.
  - Write EOI → PENDING = 0x20, CAUSE = 0x80000005, irq_out = 1 two cycles after the EOI edge.
- Withdrawal: in REQUEST with source 2 pending, write MASK = 0 → irq_out = 0 after next edge, state IDLE, CAUSE = 0x00000000.
- Set wins: EDGE = 0x02. In the same cycle, write PENDING din = 0x02 and apply a rising edge on src[1] → PENDING reads 0x02 afterwards.
- Bus qualification:
  - wen = 1 with en = 0 targeting MASK → MASK unchanged.
  - read with en = 0 → dout = 0.
  - read offset 0x14 → dout = 0.

Source files
------------

// File: rtl/irq_controller_if.sv
// Peripheral bus plus CPU interrupt handshake shared by the CPU side and the
// interrupt controller.
interface irq_controller_if;
  logic        en;
  logic        wen;
  logic [31:0] address;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq_ack;
  logic        irq_out;

  modport master (
    output en, wen, address, din, irq_ack,
    input  dout, irq_out
  );

  modport slave (
    input  en, wen, address, din, irq_ack,
    output dout, irq_out
  );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending/mask/edge registers, fixed
// lowest-index priority and a single CPU request with ack / EOI handshake.
module irq_controller #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  irq_controller_if.slave bus
);

  localparam logic [4:0] OFF_PENDING = 5'h00;
  localparam logic [4:0] OFF_MASK    = 5'h04;
  localparam logic [4:0] OFF_EDGE    = 5'h08;
  localparam logic [4:0] OFF_CAUSE   = 5'h0C;
  localparam logic [4:0] OFF_EOI     = 5'h10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [NSRC-1:0] pending_reg, pending_next;
  logic [NSRC-1:0] mask_reg, mask_next;
  logic [NSRC-1:0] edge_reg, edge_next;
  logic [NSRC-1:0] src_prev_reg;
  logic [4:0]      cur_id_reg, cur_id_next;

  logic [NSRC-1:0] masked;
  logic [NSRC-1:0] set_term;
  logic [NSRC-1:0] clr_term;
  logic [4:0]      prio_id;
  logic            any_masked;
  logic [4:0]      offset;
  logic            wr;
  logic            wr_pending, wr_mask, wr_edge, wr_eoi;
  logic            eoi_fire;
  logic            irq_req;
  logic [31:0]     rd_data;

  // Only the low five address bits select a register.
  logic unused_bits;
  assign unused_bits = ^{bus.address[31:5], bus.din};

  assign offset     = bus.address[4:0];
  assign wr         = bus.en & bus.wen;
  assign wr_pending = wr && (offset == OFF_PENDING);
  assign wr_mask    = wr && (offset == OFF_MASK);
  assign wr_edge    = wr && (offset == OFF_EDGE);
  assign wr_eoi     = wr && (offset == OFF_EOI);
  assign eoi_fire   = wr_eoi && (state_reg == IN_SERVICE);

  assign masked     = pending_reg & mask_reg;
  assign any_masked = |masked;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    prio_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        prio_id = 5'(i);
      end
    end
  end

  // Set is OR-ed after the clear so a simultaneous set always wins.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_bit
      assign set_term[gi]     = edge_reg[gi] ? (src[gi] & ~src_prev_reg[gi]) : src[gi];
      assign clr_term[gi]     = (wr_pending & bus.din[gi]) |
                                (eoi_fire & (cur_id_reg == 5'(gi)));
      assign pending_next[gi] = set_term[gi] | (pending_reg[gi] & ~clr_term[gi]);
    end
  endgenerate

  assign mask_next = wr_mask ? bus.din[NSRC-1:0] : mask_reg;
  assign edge_next = wr_edge ? bus.din[NSRC-1:0] : edge_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      mask_reg     <= '0;
      edge_reg     <= '0;
      src_prev_reg <= '0;
      cur_id_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      mask_reg     <= mask_next;
      edge_reg     <= edge_next;
      src_prev_reg <= src;
      cur_id_reg   <= cur_id_next;
    end
  end

  // A withdrawn request takes precedence over a same-cycle ack.
  always_comb begin
    state_next  = state_reg;
    cur_id_next = cur_id_reg;
    case (state_reg)
      IDLE: begin
        if (any_masked) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (!any_masked) begin
          state_next = IDLE;
        end else if (bus.irq_ack) begin
          state_next  = IN_SERVICE;
          cur_id_next = prio_id;
        end
      end
      IN_SERVICE: begin
        if (wr_eoi) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    irq_req = 1'b0;
    case (state_reg)
      REQUEST: irq_req = 1'b1;
      default: irq_req = 1'b0;
    endcase
  end

  assign bus.irq_out = irq_req;

  always_comb begin
    rd_data = '0;
    if (bus.en) begin
      case (offset)
        OFF_PENDING: rd_data = 32'(pending_reg);
        OFF_MASK:    rd_data = 32'(mask_reg);
        OFF_EDGE:    rd_data = 32'(edge_reg);
        OFF_CAUSE:   rd_data = any_masked ? {1'b1, 26'd0, prio_id} : 32'd0;
        default:     rd_data = '0;
      endcase
    end
  end

  assign bus.dout = rd_data;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios followed by randomized traffic
// checked against a behavioural model of the register and request rules.
module tb_irq_controller;
  localparam int          NSRC = 8;
  localparam int unsigned FULL = 32'hFF;
  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_SERV = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NSRC-1:0] src = '0;

  irq_controller_if bus();

  irq_controller #(.NSRC(NSRC)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int unsigned m_pend, m_mask, m_edge, m_prev, m_cur;
  int          m_state;

  function automatic int unsigned lowest(input int unsigned v);
    for (int i = 0; i < 32; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic int unsigned model_read(input logic [31:0] addr);
    int unsigned mk;
    mk = m_pend & m_mask;
    case (addr[4:0])
      5'h00:   return m_pend;
      5'h04:   return m_mask;
      5'h08:   return m_edge;
      5'h0C:   return (mk != 0) ? (32'h8000_0000 | lowest(mk)) : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_edge = 0; m_prev = 0; m_cur = 0;
    m_state = S_IDLE;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the inputs currently driven; model advances alongside.
  task automatic step();
    int unsigned s, mk, set, clr, np, nm, ne, nc;
    int          ns;
    bit          wr;
    logic [4:0]  off;
    s   = 32'(src);
    mk  = m_pend & m_mask;
    wr  = bus.en && bus.wen;
    off = bus.address[4:0];
    set = (s & ~m_prev & m_edge) | (s & ~m_edge);
    clr = 0;
    if (wr && off == 5'h00) clr |= bus.din & FULL;
    if (wr && off == 5'h10 && m_state == S_SERV) clr |= (32'd1 << m_cur);
    np = set | (m_pend & ~clr);
    nm = (wr && off == 5'h04) ? (bus.din & FULL) : m_mask;
    ne = (wr && off == 5'h08) ? (bus.din & FULL) : m_edge;
    ns = m_state;
    nc = m_cur;
    if (m_state == S_IDLE) begin
      if (mk != 0) ns = S_REQ;
    end else if (m_state == S_REQ) begin
      if (mk == 0) ns = S_IDLE;
      else if (bus.irq_ack) begin
        ns = S_SERV;
        nc = lowest(mk);
      end
    end else begin
      if (wr && off == 5'h10) ns = S_IDLE;
    end
    @(posedge clk);
    #1;
    m_pend = np; m_mask = nm; m_edge = ne; m_prev = s; m_state = ns; m_cur = nc;
  endtask

  task automatic bus_idle();
    bus.en = 1'b0; bus.wen = 1'b0; bus.address = '0; bus.din = '0;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    bus.en = 1'b1; bus.wen = 1'b1; bus.address = addr; bus.din = data;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.en = 1'b1; bus.wen = 1'b0; bus.address = addr;
    #1;
    check(tag, bus.dout, exp);
    bus_idle();
  endtask

  task automatic do_reset();
    bus_idle();
    bus.irq_ack = 1'b0;
    src = '0;
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] addrs [7];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    bus_idle();
    bus.irq_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state.
    check("rst_irq", 32'(bus.irq_out), 32'd0);
    for (int i = 0; i < 6; i++) rd(addrs[i], 32'd0, "rst_reg");

    // Level-sensitive timer source.
    wr_reg(32'h04, 32'h01);
    wr_reg(32'h08, 32'h00);
    src = 8'h01;
    step();
    rd(32'h00, 32'h01, "lvl_pending");
    check("lvl_irq_early", 32'(bus.irq_out), 32'd0);
    step();
    check("lvl_irq", 32'(bus.irq_out), 32'd1);
    rd(32'h0C, 32'h8000_0000, "lvl_cause");

    // Asynchronous reset mid-cycle while requesting.
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_irq", 32'(bus.irq_out), 32'd0);
    rd(32'h00, 32'd0, "async_rst_pend");
    src = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Priority and EOI.
    wr_reg(32'h04, 32'hFF);
    wr_reg(32'h08, 32'hFF);
    step();
    src = 8'h28;
    step();
    step();
    check("prio_irq", 32'(bus.irq_out), 32'd1);
    rd(32'h0C, 32'h8000_0003, "prio_cause");
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    check("ack_irq", 32'(bus.irq_out), 32'd0);
    wr_reg(32'h10, 32'h0);
    rd(32'h00, 32'h20, "eoi_pending");
    check("eoi_irq_idle", 32'(bus.irq_out), 32'd0);
    rd(32'h0C, 32'h8000_0005, "eoi_cause");
    step();
    check("eoi_rerequest", 32'(bus.irq_out), 32'd1);

    // Withdrawal by masking.
    do_reset();
    wr_reg(32'h04, 32'h04);
    wr_reg(32'h08, 32'h00);
    src = 8'h04;
    step();
    src = 8'h00;
    step();
    check("wd_irq_before", 32'(bus.irq_out), 32'd1);
    wr_reg(32'h04, 32'h00);
    rd(32'h0C, 32'h0, "wd_cause");
    step();
    check("wd_irq", 32'(bus.irq_out), 32'd0);

    // Set wins over write-1-to-clear.
    do_reset();
    wr_reg(32'h08, 32'h02);
    step();
    src = 8'h02;
    bus.en = 1'b1; bus.wen = 1'b1; bus.address = 32'h00; bus.din = 32'h02;
    step();
    bus_idle();
    rd(32'h00, 32'h02, "set_wins");
    wr_reg(32'h00, 32'h02);
    rd(32'h00, 32'h00, "w1c");

    // Bus qualification.
    wr_reg(32'h04, 32'h5A);
    bus.en = 1'b0; bus.wen = 1'b1; bus.address = 32'h04; bus.din = 32'hFF;
    step();
    bus_idle();
    rd(32'h04, 32'h5A, "wen_no_en");
    bus.address = 32'h04;
    #1;
    check("rd_no_en", bus.dout, 32'd0);
    rd(32'h14, 32'd0, "rd_0x14");
    wr_reg(32'h04, 32'hFFFF_FFFF);
    rd(32'h04, 32'hFF, "mask_upper");

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      src          = NSRC'($urandom & $urandom);
      bus.irq_ack  = ($urandom_range(0, 3) == 0);
      bus.en       = ($urandom_range(0, 2) == 0);
      bus.wen      = $urandom_range(0, 1);
      bus.address  = ($urandom & 32'hFFFF_FFE0) | addrs[$urandom_range(0, 6)];
      bus.din      = $urandom;
      step();
      bus_idle();
      bus.irq_ack = 1'b0;
      check("rnd_irq", 32'(bus.irq_out), (m_state == S_REQ) ? 32'd1 : 32'd0);
      begin
        logic [31:0] a;
        a = addrs[$urandom_range(0, 6)];
        rd(a, model_read(a), "rnd_read");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
